// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - OPMODE field positions, X/Z select encodings and width helpers for dsp_mac_pipe
package dsp_mac_pkg;

    localparam int OP_PREADD  = 0;
    localparam int OP_PRESUB  = 1;
    localparam int OP_X_MSB   = 3;
    localparam int OP_Z_MSB   = 5;
    localparam int OP_POSTSUB = 6;
    localparam int OP_AUTOACC = 7;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_M    = 2'b01;
    localparam logic [1:0] SEL_PCIN = 2'b01;
    localparam logic [1:0] SEL_P    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    function automatic int cnt_width(input int acc_len);
        return (acc_len < 1) ? 1 : $clog2(acc_len + 1);
    endfunction

endpackage

// File: rtl/dsp_mac_postadd.sv
// rtl/dsp_mac_postadd.sv - combinational X/Z post-adder with carry, signed overflow and optional saturation (DSP_MAC_SAT_EN)
module dsp_mac_postadd #(
    parameter int P_WIDTH = 48
) (
    input  logic [P_WIDTH-1:0] x,
    input  logic [P_WIDTH-1:0] z,
    input  logic               cin,
    input  logic               sub,
    output logic [P_WIDTH-1:0] p,
    output logic               carry,
    output logic               overflow
);

    logic [P_WIDTH-1:0] x_op;
    logic               c_op;
    logic [P_WIDTH:0]   sum;

    // Z-(X+CIN) is folded into one adder as Z + ~X + ~CIN
    assign x_op     = sub ? ~x : x;
    assign c_op     = sub ? ~cin : cin;
    assign sum      = {1'b0, z} + {1'b0, x_op} + {{P_WIDTH{1'b0}}, c_op};
    assign carry    = sum[P_WIDTH];
    assign overflow = (z[P_WIDTH-1] == x_op[P_WIDTH-1]) && (sum[P_WIDTH-1] != z[P_WIDTH-1]);

`ifdef DSP_MAC_SAT_EN
    always_comb begin
        p = sum[P_WIDTH-1:0];
        if (overflow) begin
            p = z[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end
`else
    assign p = sum[P_WIDTH-1:0];
`endif

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 4-stage pre-add/multiply/post-add MAC slice with auto-accumulate; DSP_MAC_SAT_EN enables saturation
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48,
    parameter int ACC_LEN = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CE,
    input  logic                       IN_VALID,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [C_WIDTH-1:0]         C,
    input  logic [P_WIDTH-1:0]         PCIN,
    input  logic                       CARRYIN,
    input  logic [7:0]                 OPMODE,
    output logic [B_WIDTH-1:0]         BCOUT,
    output logic [A_WIDTH+B_WIDTH-1:0] M,
    output logic [P_WIDTH-1:0]         P,
    output logic [P_WIDTH-1:0]         PCOUT,
    output logic                       CARRYOUT,
    output logic                       OVERFLOW,
    output logic                       OUT_VALID,
    output logic                       ACC_DONE
);

    localparam int M_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int CNT_WIDTH = cnt_width(ACC_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);

    logic signed [A_WIDTH-1:0] a1, a2;
    logic signed [B_WIDTH-1:0] b1, d1, pre_sum, pre2;
    logic signed [C_WIDTH-1:0] c1, c2, c3;
    logic        [P_WIDTH-1:0] pcin1, pcin2, pcin3;
    logic                      cin1, cin2, cin3;
    logic        [7:0]         op1;
    logic        [7:2]         op2, op3;
    logic                      v1, v2, v3;
    logic signed [M_WIDTH-1:0] m_r;

    logic [P_WIDTH-1:0]   p_r;
    logic                 carry_r, ovf_r, out_valid_r, acc_done_r;
    logic [CNT_WIDTH-1:0] acc_cnt;

    logic [P_WIDTH-1:0] m_ext, c_ext, x_val, z_val, sum;
    logic               sum_carry, sum_ovf, acc_first, acc_last;

    always_comb begin
        pre_sum = b1;
        if (op1[OP_PREADD]) begin
            pre_sum = op1[OP_PRESUB] ? d1 - b1 : d1 + b1;
        end
    end

    assign m_ext     = P_WIDTH'(m_r);
    assign c_ext     = P_WIDTH'(c3);
    assign acc_first = op3[OP_AUTOACC] && (acc_cnt == '0);
    assign acc_last  = op3[OP_AUTOACC] && (acc_cnt == CNT_LAST);

    always_comb begin
        x_val = '0;
        case (op3[OP_X_MSB -: 2])
            SEL_ZERO: x_val = '0;
            SEL_M:    x_val = m_ext;
            SEL_P:    x_val = p_r;
            default:  x_val = c_ext;
        endcase
        z_val = '0;
        case (op3[OP_Z_MSB -: 2])
            SEL_ZERO: z_val = '0;
            SEL_PCIN: z_val = pcin3;
            SEL_P:    z_val = p_r;
            default:  z_val = c_ext;
        endcase
        // A new accumulate run must not fold in whatever P held before it
        if (acc_first) begin
            z_val = '0;
        end
    end

    dsp_mac_postadd #(.P_WIDTH(P_WIDTH)) u_postadd (
        .x        (x_val),
        .z        (z_val),
        .cin      (cin3),
        .sub      (op3[OP_POSTSUB]),
        .p        (sum),
        .carry    (sum_carry),
        .overflow (sum_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            a1 <= '0; b1 <= '0; d1 <= '0; c1 <= '0; pcin1 <= '0; cin1 <= 1'b0; op1 <= '0; v1 <= 1'b0;
            a2 <= '0; pre2 <= '0; c2 <= '0; pcin2 <= '0; cin2 <= 1'b0; op2 <= '0; v2 <= 1'b0;
            m_r <= '0; c3 <= '0; pcin3 <= '0; cin3 <= 1'b0; op3 <= '0; v3 <= 1'b0;
            p_r <= '0; carry_r <= 1'b0; ovf_r <= 1'b0; acc_cnt <= '0;
            out_valid_r <= 1'b0; acc_done_r <= 1'b0;
        end else begin
            out_valid_r <= CE & v3;
            acc_done_r  <= CE & v3 & acc_last;
            if (CE) begin
                a1 <= A; b1 <= B; d1 <= D; c1 <= C; pcin1 <= PCIN; cin1 <= CARRYIN; op1 <= OPMODE; v1 <= IN_VALID;
                a2 <= a1; pre2 <= pre_sum; c2 <= c1; pcin2 <= pcin1; cin2 <= cin1; op2 <= op1[7:2]; v2 <= v1;
                m_r <= M_WIDTH'(a2) * M_WIDTH'(pre2);
                c3 <= c2; pcin3 <= pcin2; cin3 <= cin2; op3 <= op2; v3 <= v2;
                if (v3) begin
                    p_r     <= sum;
                    carry_r <= sum_carry;
                    ovf_r   <= sum_ovf;
                    acc_cnt <= (op3[OP_AUTOACC] && !acc_last) ? acc_cnt + CNT_WIDTH'(1) : '0;
                end
            end
        end
    end

    assign BCOUT     = b1;
    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign CARRYOUT  = carry_r;
    assign OVERFLOW  = ovf_r;
    assign OUT_VALID = out_valid_r;
    assign ACC_DONE  = acc_done_r;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - table-driven and sequence checks for dsp_mac_pipe
module tb_dsp_mac_pipe;

    logic        CLK = 1'b0;
    logic        RST, CE, IN_VALID, CARRYIN;
    logic [17:0] A, B, D, BCOUT;
    logic [47:0] C, PCIN, P, PCOUT;
    logic [7:0]  OPMODE;
    logic [35:0] M;
    logic        CARRYOUT, OVERFLOW, OUT_VALID, ACC_DONE;

    always #5 CLK = ~CLK;

    dsp_mac_pipe dut (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
        .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT),
        .OVERFLOW(OVERFLOW), .OUT_VALID(OUT_VALID), .ACC_DONE(ACC_DONE)
    );

`ifdef DSP_MAC_SAT_EN
    localparam logic [47:0] EXP_POS_OVF = 48'h7FFF_FFFF_FFFF;
    localparam logic [47:0] EXP_NEG_OVF = 48'h8000_0000_0000;
`else
    localparam logic [47:0] EXP_POS_OVF = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] EXP_NEG_OVF = 48'h7FFF_FFFF_FFFF;
`endif

    typedef struct {
        logic signed [17:0] a, b, d;
        logic [47:0]        c, pcin;
        logic               cin;
        logic [7:0]         op;
        logic [35:0]        m;
        logic [47:0]        p;
        logic               co, ovf;
    } vec_t;

    vec_t vecs[9];

    int n_cmp = 0;
    int n_err = 0;

    int          sch_ce[32], sch_iv[32], sch_rst[32], sch_a[32];
    logic [47:0] exp_p[8];
    logic        exp_done[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_sched();
        for (int t = 0; t < 32; t++) begin
            sch_ce[t] = 1; sch_iv[t] = 0; sch_rst[t] = 0; sch_a[t] = 0;
        end
    endtask

    task automatic set_sample(input int t, input int a);
        sch_iv[t] = 1;
        sch_a[t]  = a;
    endtask

    // Per cycle: check the edge just passed, then drive the next schedule slot
    task automatic run_seq(input string name, input int n, input int n_exp);
        int          k = 0;
        logic        ce_prev = 1'b1;
        logic        rst_prev = 1'b0;
        logic [47:0] p_hold;
        p_hold = P;
        for (int t = 0; t < n; t++) begin
            @(negedge CLK);
            if (rst_prev) begin
                chk({name, "_rst_p"}, 64'(P), 64'd0);
                chk({name, "_rst_valid"}, 64'(OUT_VALID), 64'd0);
                chk({name, "_rst_done"}, 64'(ACC_DONE), 64'd0);
            end else if (!ce_prev) begin
                chk({name, "_hold_valid"}, 64'(OUT_VALID), 64'd0);
                chk({name, "_hold_p"}, 64'(P), 64'(p_hold));
            end
            if (OUT_VALID) begin
                if (k < n_exp) begin
                    chk($sformatf("%s_p%0d", name, k), 64'(P), 64'(exp_p[k]));
                    chk($sformatf("%s_done%0d", name, k), 64'(ACC_DONE), 64'(exp_done[k]));
                end else begin
                    chk({name, "_extra_out"}, 64'd1, 64'd0);
                end
                k++;
            end
            p_hold   = P;
            CE       = 1'(sch_ce[t]);
            IN_VALID = 1'(sch_iv[t]);
            RST      = 1'(sch_rst[t]);
            A        = 18'(sch_a[t]);
            ce_prev  = 1'(sch_ce[t]);
            rst_prev = 1'(sch_rst[t]);
        end
        chk({name, "_count"}, 64'(k), 64'(n_exp));
    endtask

    initial begin
        vecs[0] = '{18'sd3,    18'sd5,  18'sd2,      48'd0,                48'd0,    1'b0, 8'h05, 36'd21,          48'd21,               1'b0, 1'b0};
        vecs[1] = '{-18'sd4,   18'sd7,  18'sd3,      48'd100,              48'd0,    1'b0, 8'h77, 36'd16,          48'd84,               1'b1, 1'b0};
        vecs[2] = '{18'sd0,    18'sd0,  18'sd0,      48'h7FFF_FFFF_FFFF,   48'd0,    1'b1, 8'h3C, 36'd0,           EXP_POS_OVF,          1'b0, 1'b1};
        vecs[3] = '{18'sd0,    18'sd0,  18'sd0,      48'hFFFF_FFFF_FFFF,   48'd1000, 1'b0, 8'h1C, 36'd0,           48'd999,              1'b1, 1'b0};
        vecs[4] = '{-18'sd3,   -18'sd5, 18'sd0,      48'd0,                48'd0,    1'b0, 8'h04, 36'd15,          48'd15,               1'b0, 1'b0};
        vecs[5] = '{18'sd100,  18'sd10, 18'sd0,      48'd0,                48'd0,    1'b0, 8'h07, 36'hF_FFFF_FC18, 48'hFFFF_FFFF_FC18,   1'b0, 1'b0};
        vecs[6] = '{18'sd0,    18'sd0,  18'sd0,      48'd1000,             48'd0,    1'b0, 8'h2C, 36'd0,           48'd0,                1'b1, 1'b0};
        vecs[7] = '{18'sd1,    18'sd1,  18'sd0,      48'h8000_0000_0000,   48'd0,    1'b0, 8'h74, 36'd1,           EXP_NEG_OVF,          1'b1, 1'b1};
        vecs[8] = '{18'sd1,    18'sd1,  18'sd131071, 48'd0,                48'd0,    1'b0, 8'h05, 36'hF_FFFE_0000, 48'hFFFF_FFFE_0000,   1'b0, 1'b0};

        RST = 1'b1; CE = 1'b1; IN_VALID = 1'b1; CARRYIN = 1'b1;
        A = 18'd3; B = 18'd5; D = 18'd2; C = 48'd7; PCIN = 48'd9; OPMODE = 8'h05;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_p", 64'(P), 64'd0);
        chk("reset_m", 64'(M), 64'd0);
        chk("reset_bcout", 64'(BCOUT), 64'd0);
        chk("reset_valid", 64'(OUT_VALID), 64'd0);
        chk("reset_done", 64'(ACC_DONE), 64'd0);
        chk("reset_carry", 64'(CARRYOUT), 64'd0);
        chk("reset_ovf", 64'(OVERFLOW), 64'd0);
        RST = 1'b0; IN_VALID = 1'b0;
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            int lat;
            A = vecs[i].a; B = vecs[i].b; D = vecs[i].d; C = vecs[i].c; PCIN = vecs[i].pcin;
            CARRYIN = vecs[i].cin; OPMODE = vecs[i].op; IN_VALID = 1'b1;
            lat = 0;
            do begin
                @(negedge CLK);
                IN_VALID = 1'b0;
                lat++;
            end while (!OUT_VALID && lat < 10);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_m", i), 64'(M), 64'(vecs[i].m));
            chk($sformatf("vec%0d_p", i), 64'(P), 64'(vecs[i].p));
            chk($sformatf("vec%0d_pcout", i), 64'(PCOUT), 64'(vecs[i].p));
            chk($sformatf("vec%0d_carry", i), 64'(CARRYOUT), 64'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i), 64'(OVERFLOW), 64'(vecs[i].ovf));
            repeat (2) @(negedge CLK);
        end

        B = 18'd2; D = 18'd0; C = 48'd0; PCIN = 48'd0; CARRYIN = 1'b0; OPMODE = 8'hA4;

        clr_sched();
        for (int t = 0; t < 5; t++) set_sample(t, t + 1);
        exp_p = '{48'd2, 48'd6, 48'd12, 48'd20, 48'd10, 48'd0, 48'd0, 48'd0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq("acc", 10, 5);

        // Close the open run so the next sequence starts from a cleared count
        clr_sched();
        for (int t = 0; t < 3; t++) set_sample(t, 1);
        exp_p = '{48'd12, 48'd14, 48'd16, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq("acc_close", 8, 3);

        clr_sched();
        set_sample(0, 1);
        set_sample(1, 2);
        for (int t = 2; t < 5; t++) begin
            sch_ce[t] = 0; sch_iv[t] = 1; sch_a[t] = 9;
        end
        set_sample(5, 3);
        set_sample(6, 4);
        exp_p = '{48'd2, 48'd6, 48'd12, 48'd20, 48'd0, 48'd0, 48'd0, 48'd0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq("ce", 14, 4);

        clr_sched();
        set_sample(0, 1);
        set_sample(1, 2);
        sch_rst[6] = 1;
        for (int t = 0; t < 4; t++) set_sample(7 + t, t + 1);
        exp_p = '{48'd2, 48'd6, 48'd2, 48'd6, 48'd12, 48'd20, 48'd0, 48'd0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        run_seq("rst", 17, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
